// File: rtl/keypad_matrix_scanner.sv
// Scans a 4x3 membrane keypad one column at a time, then debounces and decodes a single key
// into the one-hot digit bus, the active-low start/clear strobes and a press-accept pulse.
module keypad_matrix_scanner #(
   parameter int SCAN_CYCLES     = 3,
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [2:0] col_n,
   output logic [9:0] keypad,
   output logic       startn,
   output logic       clearn,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int DWELL_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_t;

   state_t             state, state_nxt;
   logic [3:0]         rs_p0, rs_p1;
   logic [1:0]         col_idx, col_idx_nxt;
   logic [DWELL_W-1:0] dwell, dwell_nxt;
   logic [DEB_W-1:0]   cnt, cnt_nxt;
   logic [1:0]         cand_row, cand_row_nxt;
   logic [3:0]         cand_mask;
   logic [3:0]         key_dec;
   logic [9:0]         keypad_nxt;
   logic               startn_nxt, clearn_nxt, key_valid_nxt;
   logic [3:0]         key_code_nxt;

   function automatic logic one_low(input logic [3:0] v);
      return ($countones(~v) == 1);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [1:0] next_col(input logic [1:0] c);
      return (c == 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   // Layout: rows 0-2 carry digits 1-9 left to right, row 3 is '*' '0' '#'.
   function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = 4'd10;
            2'd1:    code = 4'd0;
            default: code = 4'd11;
         endcase
      end else begin
         code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

   assign cand_mask = ~(4'b0001 << cand_row);
   assign key_dec   = decode_key(cand_row, col_idx);

   always_comb begin
      state_nxt     = state;
      col_idx_nxt   = col_idx;
      dwell_nxt     = dwell;
      cnt_nxt       = cnt;
      cand_row_nxt  = cand_row;
      keypad_nxt    = keypad;
      startn_nxt    = startn;
      clearn_nxt    = clearn;
      key_valid_nxt = 1'b0;
      key_code_nxt  = key_code;

      case (state)
         ST_SCAN: begin
            // The synchronizer needs two cycles to show the new column, so only the last dwell cycle is sampled.
            if (dwell == DWELL_W'(SCAN_CYCLES - 1)) begin
               dwell_nxt = '0;
               if (one_low(rs_p1)) begin
                  state_nxt    = ST_DEBOUNCE;
                  cand_row_nxt = low_index(rs_p1);
                  cnt_nxt      = DEB_W'(1);
               end else begin
                  col_idx_nxt = next_col(col_idx);
               end
            end else begin
               dwell_nxt = dwell + DWELL_W'(1);
            end
         end

         ST_DEBOUNCE: begin
            if (rs_p1 != cand_mask) begin
               state_nxt = ST_SCAN;
               cnt_nxt   = '0;
               dwell_nxt = '0;
            end else if (cnt == DEB_W'(DEBOUNCE_CYCLES)) begin
               state_nxt     = ST_PRESSED;
               cnt_nxt       = '0;
               key_valid_nxt = 1'b1;
               key_code_nxt  = key_dec;
               keypad_nxt    = (key_dec <= 4'd9) ? (10'd1 << key_dec) : 10'd0;
               startn_nxt    = (key_dec != 4'd11);
               clearn_nxt    = (key_dec != 4'd10);
            end else begin
               cnt_nxt = cnt + DEB_W'(1);
            end
         end

         ST_PRESSED: begin
            // Only the accepted row is watched; any other key in the matrix is ignored.
            if (rs_p1[cand_row]) begin
               if (cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                  state_nxt = ST_RELEASE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + DEB_W'(1);
               end
            end else begin
               cnt_nxt = '0;
            end
         end

         ST_RELEASE: begin
            state_nxt   = ST_SCAN;
            keypad_nxt  = '0;
            startn_nxt  = 1'b1;
            clearn_nxt  = 1'b1;
            col_idx_nxt = next_col(col_idx);
            dwell_nxt   = '0;
         end

         default: begin
            state_nxt = ST_SCAN;
         end
      endcase
   end

   // Stage p0/p1: row synchronizer, then FSM and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_p0     <= 4'b1111;
         rs_p1     <= 4'b1111;
         state     <= ST_SCAN;
         col_idx   <= '0;
         dwell     <= '0;
         cnt       <= '0;
         cand_row  <= '0;
         col_n     <= 3'b110;
         keypad    <= '0;
         startn    <= 1'b1;
         clearn    <= 1'b1;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         rs_p0     <= row_n;
         rs_p1     <= rs_p0;
         state     <= state_nxt;
         col_idx   <= col_idx_nxt;
         dwell     <= dwell_nxt;
         cnt       <= cnt_nxt;
         cand_row  <= cand_row_nxt;
         col_n     <= ~(3'b001 << col_idx_nxt);
         keypad    <= keypad_nxt;
         startn    <= startn_nxt;
         clearn    <= clearn_nxt;
         key_valid <= key_valid_nxt;
         key_code  <= key_code_nxt;
      end
   end

endmodule
